// File: rtl/vic_pkg.sv
// vic_pkg: shared constants, MIR field layout helpers and CTRL sub-field typedef for the
// Vic-1 microsequencer. Defining VIC_UCALL_EN adds the RET/CALL bits above NEXT_ADDR.
package vic_pkg;

    localparam int VIC_ADDR_W      = 9;
    localparam int VIC_CTRL_W      = 24;
    localparam int VIC_MBR_W       = 8;
    localparam int VIC_STACK_DEPTH = 4;

    // Sequencing bits sit directly above CTRL, offsets relative to CTRL_W.
    localparam int JAMZ_OFS = 0;
    localparam int JAMN_OFS = 1;
    localparam int JMPC_OFS = 2;
    localparam int SEQ_BITS = 3;

`ifdef VIC_UCALL_EN
    localparam int UCALL_BITS = 2;
`else
    localparam int UCALL_BITS = 0;
`endif

    function automatic int word_w(input int addr_w, input int ctrl_w);
        return addr_w + SEQ_BITS + ctrl_w + UCALL_BITS;
    endfunction

    function automatic int next_addr_lsb(input int ctrl_w);
        return ctrl_w + SEQ_BITS;
    endfunction

    function automatic int call_pos(input int addr_w, input int ctrl_w);
        return ctrl_w + SEQ_BITS + addr_w;
    endfunction

    function automatic int ret_pos(input int addr_w, input int ctrl_w);
        return ctrl_w + SEQ_BITS + addr_w + 1;
    endfunction

    typedef struct packed {
        logic [7:0] alu;
        logic [8:0] c_ctrl;
        logic [2:0] mem;
        logic [3:0] b_ctrl;
    } vic_ctrl_t;

endpackage

// File: rtl/vic_microsequencer_if.sv
// vic_microsequencer_if: stall/flag/MBR inputs, control store write port and MIR/MPC outputs.
// cs_wdata widens by the RET/CALL bits when VIC_UCALL_EN is defined.
interface vic_microsequencer_if #(
    parameter int ADDR_W = vic_pkg::VIC_ADDR_W,
    parameter int CTRL_W = vic_pkg::VIC_CTRL_W,
    parameter int MBR_W  = vic_pkg::VIC_MBR_W
);
    localparam int WORD_W = vic_pkg::word_w(ADDR_W, CTRL_W);

    logic              stall;
    logic              alu_n;
    logic              alu_z;
    logic [MBR_W-1:0]  mbr;
    logic              cs_we;
    logic [ADDR_W-1:0] cs_waddr;
    logic [WORD_W-1:0] cs_wdata;
    logic [CTRL_W-1:0] mir_ctrl;
    logic [ADDR_W-1:0] mpc;
    logic              stack_err;

    modport master (
        output stall, alu_n, alu_z, mbr, cs_we, cs_waddr, cs_wdata,
        input  mir_ctrl, mpc, stack_err
    );

    modport slave (
        input  stall, alu_n, alu_z, mbr, cs_we, cs_waddr, cs_wdata,
        output mir_ctrl, mpc, stack_err
    );
endinterface

// File: rtl/vic_ustack.sv
// vic_ustack: small LIFO holding micro-return addresses; push when full and pop when
// empty are ignored here, the caller reports them.
module vic_ustack #(
    parameter int DEPTH = 4,
    parameter int W     = 9
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push_i,
    input  logic         pop_i,
    input  logic [W-1:0] data_i,
    output logic         full_o,
    output logic         empty_o,
    output logic [W-1:0] top_o
);
    localparam int PW = $clog2(DEPTH + 1);
    localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [W-1:0]  mem_q [DEPTH];
    logic [PW-1:0] sp_q, sp_d;
    logic [PW-1:0] top_ptr;

    assign full_o  = (sp_q == PW'(DEPTH));
    assign empty_o = (sp_q == '0);
    assign top_ptr = sp_q - PW'(1);
    assign top_o   = empty_o ? '0 : mem_q[top_ptr[IW-1:0]];

    // NOTE: every signal assigned in always_comb gets a default first, otherwise a latch is inferred.
    always_comb begin
        sp_d = sp_q;
        if (push_i && !full_o) begin
            sp_d = sp_q + PW'(1);
        end else if (pop_i && !empty_o) begin
            sp_d = sp_q - PW'(1);
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sp_q <= '0;
        end else begin
            sp_q <= sp_d;
        end
    end

    // NOTE: storage arrays are deliberately not reset; only the pointer defines validity.
    always_ff @(posedge clk) begin
        if (push_i && !full_o) begin
            mem_q[sp_q[IW-1:0]] <= data_i;
        end
    end

endmodule

// File: rtl/vic_microsequencer.sv
// vic_microsequencer: writable control store, MPC/MIR registers and Mic-1 JAMN/JAMZ/JMPC
// next-address logic with stall. Define VIC_UCALL_EN for micro call/return via vic_ustack.
module vic_microsequencer
    import vic_pkg::*;
#(
    parameter int ADDR_W      = VIC_ADDR_W,
    parameter int CTRL_W      = VIC_CTRL_W,
    parameter int MBR_W       = VIC_MBR_W,
    parameter int STACK_DEPTH = VIC_STACK_DEPTH
) (
    input  logic                clock,
    input  logic                reset,
    vic_microsequencer_if.slave bus
);
    localparam int WORD_W   = word_w(ADDR_W, CTRL_W);
    localparam int CS_DEPTH = 1 << ADDR_W;
    localparam int NA_LSB   = next_addr_lsb(CTRL_W);

    logic [WORD_W-1:0] store_q [CS_DEPTH];
    logic [WORD_W-1:0] mir_q, mir_d;
    logic [ADDR_W-1:0] mpc_q, mpc_d;

    logic [ADDR_W-1:0] next_field;
    logic [ADDR_W-1:0] jam_addr;
    logic              jmpc, jamn, jamz, hi;

    assign next_field = mir_q[NA_LSB +: ADDR_W];
    assign jmpc       = mir_q[CTRL_W + JMPC_OFS];
    assign jamn       = mir_q[CTRL_W + JAMN_OFS];
    assign jamz       = mir_q[CTRL_W + JAMZ_OFS];
    assign hi         = (jamn & bus.alu_n) | (jamz & bus.alu_z);

    // Pure bit-OR onto NEXT_ADDR: the high bit and the MBR opcode never carry.
    assign jam_addr = next_field
                    | {hi, {(ADDR_W-1){1'b0}}}
                    | ({ADDR_W{jmpc}} & ADDR_W'(bus.mbr));

`ifdef VIC_UCALL_EN
    logic              ret_f, call_f;
    logic              push, pop, err_d, stack_err_q;
    logic              st_full, st_empty;
    logic [ADDR_W-1:0] st_top, ret_addr;

    assign ret_f    = mir_q[ret_pos(ADDR_W, CTRL_W)];
    assign call_f   = mir_q[call_pos(ADDR_W, CTRL_W)];
    assign ret_addr = mpc_q + ADDR_W'(1);

    // RET has priority over CALL; a failed pop falls back to the jammed address.
    always_comb begin
        mpc_d = jam_addr;
        push  = 1'b0;
        pop   = 1'b0;
        err_d = 1'b0;
        if (ret_f) begin
            if (st_empty) begin
                err_d = 1'b1;
            end else begin
                pop   = 1'b1;
                mpc_d = st_top;
            end
        end else if (call_f) begin
            if (st_full) begin
                err_d = 1'b1;
            end else begin
                push = 1'b1;
            end
        end
        if (bus.stall) begin
            push  = 1'b0;
            pop   = 1'b0;
            err_d = 1'b0;
        end
    end

    vic_ustack #(
        .DEPTH (STACK_DEPTH),
        .W     (ADDR_W)
    ) u_ustack (
        .clk     (clock),
        .rst_n   (reset),
        .push_i  (push),
        .pop_i   (pop),
        .data_i  (ret_addr),
        .full_o  (st_full),
        .empty_o (st_empty),
        .top_o   (st_top)
    );

    always_ff @(posedge clock) begin
        if (!reset) begin
            stack_err_q <= 1'b0;
        end else begin
            stack_err_q <= err_d;
        end
    end

    assign bus.stack_err = stack_err_q;
`else
    assign mpc_d         = jam_addr;
    assign bus.stack_err = 1'b0;
`endif

    // Write-first: a write to the address being fetched lands in the MIR directly.
    assign mir_d = (bus.cs_we && (bus.cs_waddr == mpc_d)) ? bus.cs_wdata : store_q[mpc_d];

    always_ff @(posedge clock) begin
        if (bus.cs_we) begin
            store_q[bus.cs_waddr] <= bus.cs_wdata;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            mpc_q <= '0;
            mir_q <= '0;
        end else if (!bus.stall) begin
            mpc_q <= mpc_d;
            mir_q <= mir_d;
        end
    end

    assign bus.mir_ctrl = mir_q[CTRL_W-1:0];
    assign bus.mpc      = mpc_q;

endmodule

// File: tb/tb_vic_microsequencer.sv
// tb_vic_microsequencer: table-driven checks of fetch, jam, JMPC, stall and write-first,
// hand sequences for reset-during-stall and (with VIC_UCALL_EN, depth 2) call/return.
module tb_vic_microsequencer;

    localparam int ADDR_W = 9;
    localparam int CTRL_W = 24;
    localparam int MBR_W  = 8;
`ifdef VIC_UCALL_EN
    localparam int STACK_DEPTH = 2;
    localparam int WORD_W      = 38;
`else
    localparam int STACK_DEPTH = 4;
    localparam int WORD_W      = 36;
`endif

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    vic_microsequencer_if #(.ADDR_W(ADDR_W), .CTRL_W(CTRL_W), .MBR_W(MBR_W)) bus ();

    vic_microsequencer #(
        .ADDR_W      (ADDR_W),
        .CTRL_W      (CTRL_W),
        .MBR_W       (MBR_W),
        .STACK_DEPTH (STACK_DEPTH)
    ) dut (
        .clock (clk),
        .reset (rst_n),
        .bus   (bus)
    );

    int n_checks = 0;
    int n_pass   = 0;

    typedef struct {
        logic              stall;
        logic              alu_n;
        logic              alu_z;
        logic [MBR_W-1:0]  mbr;
        logic              cs_we;
        logic [ADDR_W-1:0] cs_waddr;
        logic [WORD_W-1:0] cs_wdata;
        logic [ADDR_W-1:0] exp_mpc;
        logic [CTRL_W-1:0] exp_ctrl;
    } vec_t;

    typedef struct {
        logic [ADDR_W-1:0] addr;
        logic [WORD_W-1:0] word;
    } cs_entry_t;

    vec_t      vecs[$];
    cs_entry_t prog[$];

    // Layout MSB->LSB: RET, CALL, NEXT_ADDR[8:0], JMPC, JAMN, JAMZ, CTRL[23:0].
    function automatic logic [WORD_W-1:0] mk(input logic [8:0] na, input logic jmpc,
                                             input logic jamn, input logic jamz,
                                             input logic [23:0] ctrl,
                                             input logic call = 1'b0, input logic ret = 1'b0);
        logic [37:0] full;
        full = {ret, call, na, jmpc, jamn, jamz, ctrl};
        return full[WORD_W-1:0];
    endfunction

    function automatic vec_t v(input logic stall, input logic n, input logic z,
                               input logic [7:0] mbr, input logic we, input logic [8:0] wa,
                               input logic [WORD_W-1:0] wd, input logic [8:0] mpc,
                               input logic [23:0] ctrl);
        vec_t r;
        r.stall = stall; r.alu_n = n; r.alu_z = z; r.mbr = mbr;
        r.cs_we = we; r.cs_waddr = wa; r.cs_wdata = wd;
        r.exp_mpc = mpc; r.exp_ctrl = ctrl;
        return r;
    endfunction

    function automatic cs_entry_t e(input logic [8:0] a, input logic [WORD_W-1:0] w);
        cs_entry_t r;
        r.addr = a; r.word = w;
        return r;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end else begin
            n_pass++;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic stall, input logic n, input logic z, input logic [7:0] mbr);
        bus.stall = stall; bus.alu_n = n; bus.alu_z = z; bus.mbr = mbr;
        bus.cs_we = 1'b0;
    endtask

    task automatic step_chk(input string tag, input logic [7:0] mbr, input logic z,
                            input logic [8:0] exp_mpc, input logic exp_err);
        drive(1'b0, 1'b0, z, mbr);
        tick();
        check({tag, " mpc"}, 64'(bus.mpc), 64'(exp_mpc));
        check({tag, " stack_err"}, 64'(bus.stack_err), 64'(exp_err));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: run did not complete");
        $fatal(1);
    end

    initial begin
        drive(1'b0, 1'b0, 1'b0, 8'h00);
        bus.cs_waddr = '0;
        bus.cs_wdata = '0;

        prog.push_back(e(9'h000, mk(9'h005, 0, 0, 0, 24'h0ABCDE)));
        prog.push_back(e(9'h005, mk(9'h012, 0, 0, 1, 24'h000005)));
        prog.push_back(e(9'h112, mk(9'h005, 0, 0, 0, 24'h000112)));
        prog.push_back(e(9'h012, mk(9'h006, 0, 0, 0, 24'h000012)));
        prog.push_back(e(9'h006, mk(9'h030, 0, 1, 0, 24'h000006)));
        prog.push_back(e(9'h130, mk(9'h006, 0, 0, 0, 24'h000130)));
        prog.push_back(e(9'h030, mk(9'h000, 1, 0, 0, 24'h000030)));
        prog.push_back(e(9'h010, mk(9'h011, 0, 0, 0, 24'h000010)));
        prog.push_back(e(9'h011, mk(9'h040, 0, 0, 0, 24'h000011)));
        prog.push_back(e(9'h040, mk(9'h041, 0, 0, 0, 24'h000040)));
        prog.push_back(e(9'h041, mk(9'h042, 0, 0, 0, 24'h000041)));
        prog.push_back(e(9'h042, mk(9'h001, 1, 1, 0, 24'h000042)));
        prog.push_back(e(9'h183, mk(9'h000, 0, 0, 0, 24'h000183)));
        prog.push_back(e(9'h003, mk(9'h000, 0, 0, 0, 24'h000003)));
`ifdef VIC_UCALL_EN
        prog.push_back(e(9'h020, mk(9'h100, 0, 0, 0, 24'h000020, 1'b1, 1'b0)));
        prog.push_back(e(9'h100, mk(9'h077, 0, 0, 0, 24'h000100, 1'b0, 1'b1)));
        prog.push_back(e(9'h021, mk(9'h101, 0, 0, 0, 24'h000021, 1'b1, 1'b0)));
        prog.push_back(e(9'h101, mk(9'h102, 0, 0, 0, 24'h000101, 1'b1, 1'b0)));
        prog.push_back(e(9'h102, mk(9'h103, 0, 0, 0, 24'h000102, 1'b1, 1'b0)));
        prog.push_back(e(9'h103, mk(9'h104, 0, 0, 0, 24'h000103, 1'b0, 1'b1)));
        prog.push_back(e(9'h044, mk(9'h045, 0, 0, 0, 24'h000044, 1'b0, 1'b1)));
        prog.push_back(e(9'h045, mk(9'h046, 0, 0, 0, 24'h000045, 1'b1, 1'b1)));
        prog.push_back(e(9'h046, mk(9'h047, 0, 0, 0, 24'h000046, 1'b0, 1'b1)));
`endif

        // {stall, n, z, mbr, cs_we, cs_waddr, cs_wdata, exp mpc, exp mir_ctrl}
        vecs.push_back(v(0, 0, 0, 8'h00, 0, 9'h000, '0, 9'h000, 24'h0ABCDE));
        vecs.push_back(v(0, 1, 1, 8'h00, 0, 9'h000, '0, 9'h005, 24'h000005));
        vecs.push_back(v(0, 0, 1, 8'h00, 0, 9'h000, '0, 9'h112, 24'h000112));
        vecs.push_back(v(0, 0, 0, 8'h00, 0, 9'h000, '0, 9'h005, 24'h000005));
        vecs.push_back(v(0, 1, 0, 8'h00, 0, 9'h000, '0, 9'h012, 24'h000012));
        vecs.push_back(v(0, 0, 0, 8'h00, 0, 9'h000, '0, 9'h006, 24'h000006));
        vecs.push_back(v(0, 1, 0, 8'h00, 0, 9'h000, '0, 9'h130, 24'h000130));
        vecs.push_back(v(0, 0, 1, 8'h00, 0, 9'h000, '0, 9'h006, 24'h000006));
        vecs.push_back(v(0, 0, 1, 8'h00, 0, 9'h000, '0, 9'h030, 24'h000030));
        vecs.push_back(v(0, 0, 0, 8'h10, 0, 9'h000, '0, 9'h010, 24'h000010));
        vecs.push_back(v(0, 0, 0, 8'hFF, 0, 9'h000, '0, 9'h011, 24'h000011));
        vecs.push_back(v(0, 0, 0, 8'h00, 0, 9'h000, '0, 9'h040, 24'h000040));
        vecs.push_back(v(0, 0, 0, 8'h00, 0, 9'h000, '0, 9'h041, 24'h000041));
        vecs.push_back(v(0, 0, 0, 8'h00, 0, 9'h000, '0, 9'h042, 24'h000042));
        vecs.push_back(v(0, 1, 0, 8'h83, 0, 9'h000, '0, 9'h183, 24'h000183));
        vecs.push_back(v(0, 0, 0, 8'h00, 0, 9'h000, '0, 9'h000, 24'h0ABCDE));
        vecs.push_back(v(0, 0, 0, 8'h00, 0, 9'h000, '0, 9'h005, 24'h000005));
        vecs.push_back(v(1, 0, 1, 8'h00, 0, 9'h000, '0, 9'h005, 24'h000005));
        vecs.push_back(v(1, 1, 1, 8'hFF, 0, 9'h000, '0, 9'h005, 24'h000005));
        vecs.push_back(v(1, 0, 0, 8'h00, 0, 9'h000, '0, 9'h005, 24'h000005));
        vecs.push_back(v(0, 0, 0, 8'h00, 0, 9'h000, '0, 9'h012, 24'h000012));
        vecs.push_back(v(0, 0, 0, 8'h00, 1, 9'h006, mk(9'h030, 0, 0, 0, 24'h5A5A5A),
                         9'h006, 24'h5A5A5A));
        vecs.push_back(v(0, 1, 0, 8'h00, 0, 9'h000, '0, 9'h030, 24'h000030));
        vecs.push_back(v(0, 0, 0, 8'h03, 1, 9'h1FF, mk(9'h000, 0, 0, 0, 24'hFFFFFF),
                         9'h003, 24'h000003));
        vecs.push_back(v(0, 0, 0, 8'h00, 0, 9'h000, '0, 9'h000, 24'h0ABCDE));

        // Load the control store while reset is held.
        foreach (prog[i]) begin
            bus.cs_we    = 1'b1;
            bus.cs_waddr = prog[i].addr;
            bus.cs_wdata = prog[i].word;
            tick();
        end
        bus.cs_we = 1'b0;
        tick();
        check("reset mpc", 64'(bus.mpc), 64'h0);
        check("reset mir_ctrl", 64'(bus.mir_ctrl), 64'h0);
        check("reset stack_err", 64'(bus.stack_err), 64'h0);

        rst_n = 1'b1;
        foreach (vecs[i]) begin
            bus.stall    = vecs[i].stall;
            bus.alu_n    = vecs[i].alu_n;
            bus.alu_z    = vecs[i].alu_z;
            bus.mbr      = vecs[i].mbr;
            bus.cs_we    = vecs[i].cs_we;
            bus.cs_waddr = vecs[i].cs_waddr;
            bus.cs_wdata = vecs[i].cs_wdata;
            tick();
            check($sformatf("vec%0d mpc", i), 64'(bus.mpc), 64'(vecs[i].exp_mpc));
            check($sformatf("vec%0d mir_ctrl", i), 64'(bus.mir_ctrl), 64'(vecs[i].exp_ctrl));
        end

        // Reset during a stall wins, and blocks a write-first hit on the MIR.
        drive(1'b0, 1'b0, 1'b0, 8'h00);
        tick();
        check("pre-stall mpc", 64'(bus.mpc), 64'h005);
        drive(1'b1, 1'b0, 1'b0, 8'h00);
        tick();
        check("stall hold mpc", 64'(bus.mpc), 64'h005);
        check("stall hold mir_ctrl", 64'(bus.mir_ctrl), 64'h000005);
        drive(1'b1, 1'b0, 1'b0, 8'h00);
        rst_n        = 1'b0;
        bus.cs_we    = 1'b1;
        bus.cs_waddr = 9'h012;
        bus.cs_wdata = mk(9'h006, 0, 0, 0, 24'h000012);
        tick();
        check("rst-in-stall mpc", 64'(bus.mpc), 64'h0);
        check("rst-in-stall mir_ctrl", 64'(bus.mir_ctrl), 64'h0);
        check("rst-in-stall stack_err", 64'(bus.stack_err), 64'h0);
        drive(1'b1, 1'b0, 1'b0, 8'h00);
        rst_n = 1'b1;
        tick();
        check("post-rst stall mpc", 64'(bus.mpc), 64'h0);
        check("post-rst stall mir_ctrl", 64'(bus.mir_ctrl), 64'h0);
        drive(1'b0, 1'b0, 1'b0, 8'h00);
        tick();
        check("first fetch mpc", 64'(bus.mpc), 64'h0);
        check("first fetch mir_ctrl", 64'(bus.mir_ctrl), 64'h0ABCDE);
        tick();
        check("second fetch mpc", 64'(bus.mpc), 64'h005);

`ifdef VIC_UCALL_EN
        // Reach CALL at 0x020 through the JMPC entry at 0x030.
        step_chk("u walk0", 8'h00, 1'b0, 9'h012, 1'b0);
        step_chk("u walk1", 8'h00, 1'b0, 9'h006, 1'b0);
        step_chk("u walk2", 8'h00, 1'b0, 9'h030, 1'b0);
        step_chk("u jmpc20", 8'h20, 1'b0, 9'h020, 1'b0);
        step_chk("u call", 8'h00, 1'b0, 9'h100, 1'b0);
        step_chk("u ret", 8'h00, 1'b0, 9'h021, 1'b0);
        step_chk("u nest1", 8'h00, 1'b0, 9'h101, 1'b0);
        step_chk("u nest2", 8'h00, 1'b0, 9'h102, 1'b0);
        step_chk("u overflow", 8'h00, 1'b0, 9'h103, 1'b1);
        step_chk("u ret after ovf", 8'h00, 1'b0, 9'h102, 1'b0);

        rst_n = 1'b0;
        tick();
        check("u reset mpc", 64'(bus.mpc), 64'h0);
        rst_n = 1'b1;
        step_chk("u refetch", 8'h00, 1'b0, 9'h000, 1'b0);
        step_chk("u walk3", 8'h00, 1'b0, 9'h005, 1'b0);
        step_chk("u walk4", 8'h00, 1'b0, 9'h012, 1'b0);
        step_chk("u walk5", 8'h00, 1'b0, 9'h006, 1'b0);
        step_chk("u walk6", 8'h00, 1'b0, 9'h030, 1'b0);
        step_chk("u jmpc44", 8'h44, 1'b0, 9'h044, 1'b0);
        step_chk("u ret empty", 8'h00, 1'b0, 9'h045, 1'b1);
        step_chk("u call+ret empty", 8'h00, 1'b0, 9'h046, 1'b1);
        step_chk("u ret still empty", 8'h00, 1'b0, 9'h047, 1'b1);
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
